bitmask_scanner: RTL and testbench
==================================

Name: bitmask_scanner

Overview:
- Sequential, parametrised successor to the 8-to-3 leading-one encoder.
- Accepts one WIDTH-bit essential-bit mask per transaction.
- Emits the index of every set bit in order, MSB first, one index per output beat. Each emitted bit is cleared from an internal residual register.
- Sits between the bit-mask generator and the bit-serial PE shift control, so zero bits cost no cycles.

Parameters:
- WIDTH, 8, mask width in bits (≥2).
- IDX_W, $clog2(WIDTH), width of emitted index.
- MAX_BITS, WIDTH, maximum beats emitted per mask; remaining set bits are dropped and flagged.
- CNT_W, $clog2(MAX_BITS+1), width of the beat counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous abort; drops current mask, returns to IDLE
- in_valid  input  1  mask valid
- in_ready  output  1  scanner can accept a mask this cycle
- in_bitmask  input  WIDTH  essential-bit mask
- out_valid  output  1  index beat valid
- out_ready  input  1  consumer accepts beat
- out_idx  output  IDX_W  position of current leading one; bit WIDTH-1 → 0, bit 0 → WIDTH-1
- out_last  output  1  final beat of this mask
- out_is_zero  output  1  mask was all-zero (single beat, out_idx=0)
- out_trunc  output  1  valid on last beat; set bits remained when MAX_BITS beats were reached

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n), all state cleared on assertion.
- Reset values:
  - state=IDLE, residual=0, beat count=0.
  - out_valid=0, out_idx=0, out_last=0, out_is_zero=0, out_trunc=0, in_ready=1.
- States: IDLE, SCAN.
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last). This allows back-to-back masks with no bubble.
- Accept (in_valid & in_ready):
  - residual <= in_bitmask, count <= 0, zero flag <= (in_bitmask==0).
  - Go to SCAN; out_valid is high the next cycle. Latency is 1 cycle.
- SCAN outputs are combinational from registers only (no in_* → out_* path):
  - out_idx = leading-one index of residual; 0 if residual is 0.
  - out_is_zero = zero flag.
  - out_last = zero flag | (popcount(residual)==1) | (count==MAX_BITS-1).
  - out_trunc = out_last & (popcount(residual)>1).
- Output handshake (out_valid & out_ready):
  - Clear the residual bit at out_idx and increment count.
  - If out_last, go to IDLE, unless a new mask is accepted in the same cycle, in which case stay in SCAN with the new mask loaded.
- Backpressure: while out_valid & !out_ready, out_idx, out_last, out_is_zero and out_trunc hold stable and the residual does not change.
- Beat count:
  - Nonzero mask: min(popcount, MAX_BITS) beats.
  - Zero mask: exactly 1 beat with out_is_zero=1, out_last=1, out_idx=0.
- clear:
  - Takes priority over all handshakes; next cycle state=IDLE, out_valid=0, residual=0.
  - An in_valid coincident with clear is not accepted; in_ready is forced to 0 that cycle.
- rst_n asserted mid-scan: immediate return to reset values; the partial mask is lost and no further beats are emitted.
- in_bitmask is ignored when in_ready=0.

Decomposition:
- Shared package pencoder_pkg:
  - function clog2_safe.
  - typedef scan_state_e {IDLE, SCAN}.
  - Width helpers for IDX_W and CNT_W.
- Sub-module pencoder_msb #(WIDTH), combinational.
  - Ports: bitmask[WIDTH] → idx[IDX_W], is_zero, onehot[WIDTH].
  - onehot gives the mask used to clear the emitted bit.
- Popcount-equals-one is detected as (residual & (residual-1))==0 with residual≠0; no full popcount is required.

Test Plan:
- Basic scan, WIDTH=8, out_ready=1, mask 8'b1010_0100 → beats out_idx 0, 2, 5 on consecutive cycles starting 1 cycle after accept; last on idx 5; out_is_zero=0; out_trunc=0.
- Zero mask, 8'h00 → single beat: out_idx=0, out_is_zero=1, out_last=1; in_ready=1 on that beat.
- Backpressure, mask 8'h81 with out_ready low for 3 cycles on the first beat → out_idx=0 held stable for 4 cycles; then idx 7 with last.
- Back-to-back:
  - Masks 8'h01 then 8'h80 presented continuously → idx 7 (last), then idx 0 (last) on the next cycle.
  - No bubble; in_ready is high on the last-beat handshake.
- Truncation, MAX_BITS=2, mask 8'hFF → beats idx 0, 1; the second beat has out_last=1 and out_trunc=1; the scanner then returns to IDLE.
- Abort and reset, WIDTH=16, mask 16'hF000:
  - clear after the first beat → out_valid=0 next cycle; the following mask 16'h0001 yields idx 15.
  - Repeat with rst_n pulsed mid-scan → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/pencoder_pkg.sv
// Shared types and width helpers for the MSB-first bit-mask scanner.
package pencoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  // Ceiling log2 that never returns 0, so a 1-entry range still gets a 1-bit field.
  function automatic int clog2_safe(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int idx_width(input int width);
    return clog2_safe(width);
  endfunction

  function automatic int cnt_width(input int max_bits);
    return clog2_safe(max_bits + 1);
  endfunction

endpackage

// File: rtl/bitmask_scanner_if.sv
// Mask-in / index-out handshake bundle between the mask generator, scanner and PE shift control.
interface bitmask_scanner_if
  import pencoder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = idx_width(WIDTH)
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_bitmask;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_is_zero;
  logic             out_trunc;

  // Scanner side.
  modport slave (
    input  in_valid,
    input  in_bitmask,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_idx,
    output out_last,
    output out_is_zero,
    output out_trunc
  );

  // Producer/consumer side.
  modport master (
    output in_valid,
    output in_bitmask,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_idx,
    input  out_last,
    input  out_is_zero,
    input  out_trunc
  );

endinterface

// File: rtl/pencoder_msb.sv
// Combinational leading-one finder: index counted from the MSB plus a one-hot of that bit.
module pencoder_msb
  import pencoder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] bitmask,
  output logic [IDX_W-1:0] idx,
  output logic             is_zero,
  output logic [WIDTH-1:0] onehot
);

  // w_above[i] is set when any bit strictly above position i is set.
  logic [WIDTH-1:0] w_above;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_above
      if (gi == WIDTH - 1) begin : g_top
        assign w_above[gi] = 1'b0;
      end else begin : g_rest
        assign w_above[gi] = |bitmask[WIDTH-1:gi+1];
      end
    end

    for (gi = 0; gi < WIDTH; gi++) begin : g_onehot
      assign onehot[gi] = bitmask[gi] & ~w_above[gi];
    end
  endgenerate

  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (onehot[i]) begin
        idx = idx | IDX_W'(WIDTH - 1 - i);
      end
    end
  end

  assign is_zero = ~|bitmask;

endmodule

// File: rtl/bitmask_scanner.sv
// Sequential MSB-first scanner: one accepted mask becomes one index beat per set bit.
module bitmask_scanner
  import pencoder_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int IDX_W    = idx_width(WIDTH),
  parameter int MAX_BITS = WIDTH,
  parameter int CNT_W    = cnt_width(MAX_BITS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  bitmask_scanner_if.slave  bus
);

  scan_state_e      r_state;
  scan_state_e      w_state_next;
  logic [WIDTH-1:0] r_residual;
  logic [WIDTH-1:0] w_residual_next;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             r_zero;
  logic             w_zero_next;

  logic [IDX_W-1:0] w_msb_idx;
  logic             w_msb_is_zero;
  logic [WIDTH-1:0] w_msb_onehot;

  logic w_scan;
  logic w_single;
  logic w_last;
  logic w_fire;
  logic w_in_ready;
  logic w_accept;

  pencoder_msb #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_msb (
    .bitmask (r_residual),
    .idx     (w_msb_idx),
    .is_zero (w_msb_is_zero),
    .onehot  (w_msb_onehot)
  );

  // Exactly one bit left: x & (x-1) strips the lowest set bit.
  assign w_single = ~w_msb_is_zero &
                    ((r_residual & (r_residual - WIDTH'(1))) == '0);

  assign w_scan     = (r_state == SCAN);
  assign w_last     = r_zero | w_single | (r_count == CNT_W'(MAX_BITS - 1));
  assign w_fire     = w_scan & bus.out_ready;
  assign w_in_ready = ~clear & (~w_scan | (w_fire & w_last));
  assign w_accept   = bus.in_valid & w_in_ready;

  // Outputs depend on registers only; gated so IDLE presents all zeros.
  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_scan;
  assign bus.out_idx     = w_scan ? w_msb_idx : '0;
  assign bus.out_is_zero = w_scan & r_zero;
  assign bus.out_last    = w_scan & w_last;
  assign bus.out_trunc   = w_scan & w_last & ~w_msb_is_zero & ~w_single;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_residual <= '0;
      r_count    <= '0;
      r_zero     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_residual <= w_residual_next;
      r_count    <= w_count_next;
      r_zero     <= w_zero_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_residual_next = r_residual;
    w_count_next    = r_count;
    w_zero_next     = r_zero;

    if (clear) begin
      w_state_next    = IDLE;
      w_residual_next = '0;
      w_count_next    = '0;
      w_zero_next     = 1'b0;
    end else begin
      if (w_fire) begin
        w_residual_next = r_residual & ~w_msb_onehot;
        w_count_next    = r_count + CNT_W'(1);
        if (w_last) begin
          w_state_next = IDLE;
        end
      end
      // A new mask accepted on the last beat overrides the return to IDLE.
      if (w_accept) begin
        w_state_next    = SCAN;
        w_residual_next = bus.in_bitmask;
        w_count_next    = '0;
        w_zero_next     = (bus.in_bitmask == '0);
      end
    end
  end

endmodule

// File: tb/tb_bitmask_scanner.sv
// Scoreboard bench: accepted masks are expanded into expected beats by a reference model.
module tb_bitmask_scanner;

  localparam int WIDTH    = 16;
  localparam int MAX_BITS = 5;
  localparam int IDX_W    = 4;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             last;
    logic             zero;
    logic             trunc;
  } beat_t;

  logic clk;
  logic rst_n;
  logic clear;

  bitmask_scanner_if #(.WIDTH(WIDTH)) bus ();

  bitmask_scanner #(
    .WIDTH    (WIDTH),
    .MAX_BITS (MAX_BITS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  beat_t exp_q[$];
  int    checks;
  int    errors;
  int    masks_seen;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: walk set bits from MSB down, keep at most MAX_BITS of them.
  function automatic int push_mask(input logic [WIDTH-1:0] m);
    int    pop;
    int    n;
    int    k;
    beat_t b;
    pop = $countones(m);
    n   = (pop < MAX_BITS) ? pop : MAX_BITS;
    if (m == '0) begin
      b.idx = '0; b.last = 1'b1; b.zero = 1'b1; b.trunc = 1'b0;
      exp_q.push_back(b);
      return 1;
    end
    k = 0;
    for (int bit_i = WIDTH - 1; bit_i >= 0; bit_i--) begin
      if (m[bit_i] && k < n) begin
        b.idx   = IDX_W'(WIDTH - 1 - bit_i);
        b.last  = (k == n - 1);
        b.zero  = 1'b0;
        b.trunc = (k == n - 1) && (pop > MAX_BITS);
        exp_q.push_back(b);
        k++;
      end
    end
    return n;
  endfunction

  // Monitor: compare at the falling edge, then apply this cycle's handshakes to the model.
  always @(negedge clk) begin
    logic  exp_valid;
    logic  exp_rdy;
    beat_t f;
    int    nb;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      exp_valid = (exp_q.size() != 0);
      exp_rdy   = !clear && (exp_q.size() == 0 || (exp_q.size() == 1 && bus.out_ready));
      chk("out_valid", int'(bus.out_valid), int'(exp_valid));
      chk("in_ready", int'(bus.in_ready), int'(exp_rdy));
      if (clear) begin
        exp_q.delete();
      end else begin
        if (exp_valid && bus.out_valid) begin
          f = exp_q[0];
          chk("out_idx", int'(bus.out_idx), int'(f.idx));
          chk("out_last", int'(bus.out_last), int'(f.last));
          chk("out_is_zero", int'(bus.out_is_zero), int'(f.zero));
          chk("out_trunc", int'(bus.out_trunc), int'(f.trunc));
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
          end
        end
        if (bus.in_valid && exp_rdy) begin
          nb = push_mask(bus.in_bitmask);
          masks_seen++;
          $display("mask %0d accepted: %h -> %0d beats", masks_seen, bus.in_bitmask, nb);
        end
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] m);
    bit ok;
    ok = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_bitmask = m;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept_timeout", int'(ok), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_out_idx"}, int'(bus.out_idx), 0);
    chk({tag, "_out_last"}, int'(bus.out_last), 0);
    chk({tag, "_out_is_zero"}, int'(bus.out_is_zero), 0);
    chk({tag, "_out_trunc"}, int'(bus.out_trunc), 0);
    chk({tag, "_in_ready"}, int'(bus.in_ready), 1);
  endtask

  initial begin
    int sel;
    checks         = 0;
    errors         = 0;
    masks_seen     = 0;
    rst_n          = 1'b0;
    clear          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_bitmask = '0;
    bus.out_ready  = 1'b1;
    #2;
    chk_reset_outputs("reset");
    #10;
    rst_n = 1'b1;
    step(1);

    // Basic scan: bits 7,5,2 -> idx 8,10,13
    send(16'h00A4);
    step(4);
    // Zero mask
    send(16'h0000);
    step(2);
    // Backpressure on the first beat for 3 cycles
    bus.out_ready = 1'b0;
    send(16'h8001);
    step(3);
    bus.out_ready = 1'b1;
    step(3);
    // Back-to-back, no bubble
    send(16'h0001);
    send(16'h8000);
    step(3);
    // Truncation after MAX_BITS beats
    send(16'hFFFF);
    step(8);

    // Abort after the first beat; a mask offered during clear is refused
    send(16'hF000);
    step(1);
    clear          = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_bitmask = 16'h0001;
    step(1);
    clear = 1'b0;
    send(16'h0001);
    step(3);

    // Asynchronous reset mid-scan
    send(16'hF000);
    step(1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    step(1);
    send(16'h0001);
    step(3);

    // Randomised traffic with backpressure and occasional aborts
    for (int c = 0; c < 2500; c++) begin
      bus.in_valid = ($urandom_range(0, 99) < 60);
      sel = $urandom_range(0, 9);
      case (sel)
        0:       bus.in_bitmask = '0;
        1:       bus.in_bitmask = '1;
        2:       bus.in_bitmask = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
        3:       bus.in_bitmask = WIDTH'($urandom & $urandom);
        default: bus.in_bitmask = WIDTH'($urandom);
      endcase
      bus.out_ready = ($urandom_range(0, 99) < 75);
      clear         = ($urandom_range(0, 99) < 2);
      step(1);
    end

    // Drain
    bus.in_valid  = 1'b0;
    clear         = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      step(1);
    end
    step(2);
    chk("drain_pending", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
